// File: rtl/clock_ratio_monitor.sv
// Measures period and high phase of i_div_clk in i_ref_clk cycles and checks them against i_exp_ratio.
// Optional build macro CLK_MON_SYNC_EN puts a 2-flop synchronizer in front of the edge detector.
module clock_ratio_monitor #(
   parameter int RATIO_WD = 8,
   parameter int LOCK_CNT = 4
) (
   input  logic                i_ref_clk,
   input  logic                i_rst,
   input  logic                i_en,
   input  logic                i_div_clk,
   input  logic [RATIO_WD-1:0] i_exp_ratio,
   output logic [RATIO_WD-1:0] o_meas_ratio,
   output logic [RATIO_WD-1:0] o_meas_high,
   output logic                o_meas_valid,
   output logic                o_locked,
   output logic                o_err,
   output logic                o_timeout,
   output logic [1:0]          o_dbg_state
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [RATIO_WD-1:0] ALL_ONES = '1;
   localparam logic [MW-1:0]       LOCK_MAX = MW'(LOCK_CNT);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_RISE = 2'd1,
      ST_MEAS_HIGH = 2'd2,
      ST_MEAS_LOW  = 2'd3
   } state_t;

   logic r_s;
   logic r_s_d;

`ifdef CLK_MON_SYNC_EN
   logic r_sync;
   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= 1'b0;
         r_s    <= 1'b0;
      end else begin
         r_sync <= i_div_clk;
         r_s    <= r_sync;
      end
   end
`else
   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) r_s <= 1'b0;
      else       r_s <= i_div_clk;
   end
`endif

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) r_s_d <= 1'b0;
      else       r_s_d <= r_s;
   end

   logic w_rise;
   logic w_fall;
   logic w_active;
   assign w_rise   = r_s & ~r_s_d;
   assign w_fall   = ~r_s & r_s_d;
   assign w_active = i_en && (i_exp_ratio >= RATIO_WD'(2));

   state_t              r_state;
   logic [RATIO_WD-1:0] r_cnt;
   logic [RATIO_WD-1:0] r_high_len;
   logic [MW-1:0]       r_match_cnt;
   logic [RATIO_WD-1:0] r_meas_ratio;
   logic [RATIO_WD-1:0] r_meas_high;
   logic                r_meas_valid;
   logic                r_locked;
   logic                r_err;
   logic                r_timeout;

   state_t              w_state_nxt;
   logic [RATIO_WD-1:0] w_cnt_nxt;
   logic [RATIO_WD-1:0] w_high_nxt;
   logic [MW-1:0]       w_match_nxt;
   logic [RATIO_WD-1:0] w_meas_ratio_nxt;
   logic [RATIO_WD-1:0] w_meas_high_nxt;
   logic                w_valid_nxt;
   logic                w_locked_nxt;
   logic                w_err_nxt;
   logic                w_timeout_nxt;
   logic                w_count;

   // Period is one bit wider so an overlong period is detected instead of wrapping.
   logic [RATIO_WD:0]   w_period;
   logic                w_ovf;
   logic                w_match;
   logic [RATIO_WD-1:0] w_cnt_inc;
   logic [MW-1:0]       w_match_inc;
   assign w_period    = {1'b0, r_high_len} + {1'b0, r_cnt};
   assign w_ovf       = w_period[RATIO_WD];
   assign w_match     = !w_ovf && (w_period[RATIO_WD-1:0] == i_exp_ratio);
   assign w_cnt_inc   = r_cnt + 1'b1;
   assign w_match_inc = (r_match_cnt == LOCK_MAX) ? LOCK_MAX : r_match_cnt + 1'b1;

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_high_nxt       = r_high_len;
      w_match_nxt      = r_match_cnt;
      w_meas_ratio_nxt = r_meas_ratio;
      w_meas_high_nxt  = r_meas_high;
      w_valid_nxt      = 1'b0;
      w_locked_nxt     = r_locked;
      w_err_nxt        = 1'b0;
      w_timeout_nxt    = 1'b0;
      w_count          = 1'b0;
      if (!w_active || r_state == ST_IDLE) begin
         w_state_nxt  = w_active ? ST_WAIT_RISE : ST_IDLE;
         w_cnt_nxt    = '0;
         w_high_nxt   = '0;
         w_match_nxt  = '0;
         w_locked_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_WAIT_RISE: begin
               if (w_rise) begin
                  w_cnt_nxt   = RATIO_WD'(1);
                  w_state_nxt = ST_MEAS_HIGH;
               end else begin
                  w_count = 1'b1;
               end
            end
            ST_MEAS_HIGH: begin
               if (w_fall) begin
                  w_high_nxt  = r_cnt;
                  w_cnt_nxt   = RATIO_WD'(1);
                  w_state_nxt = ST_MEAS_LOW;
               end else begin
                  w_count = 1'b1;
               end
            end
            ST_MEAS_LOW: begin
               if (w_rise) begin
                  w_meas_ratio_nxt = w_ovf ? ALL_ONES : w_period[RATIO_WD-1:0];
                  w_meas_high_nxt  = r_high_len;
                  w_valid_nxt      = 1'b1;
                  w_cnt_nxt        = RATIO_WD'(1);
                  w_state_nxt      = ST_MEAS_HIGH;
                  if (w_match) begin
                     w_match_nxt  = w_match_inc;
                     w_locked_nxt = (w_match_inc == LOCK_MAX);
                  end else begin
                     w_err_nxt    = 1'b1;
                     w_match_nxt  = '0;
                     w_locked_nxt = 1'b0;
                  end
               end else begin
                  w_count = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
      // Edges take priority: the timeout only fires on a cycle with no qualifying edge.
      if (w_count) begin
         if (w_cnt_inc == ALL_ONES) begin
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_match_nxt   = '0;
            w_locked_nxt  = 1'b0;
            w_state_nxt   = ST_WAIT_RISE;
         end else begin
            w_cnt_nxt = w_cnt_inc;
         end
      end
   end

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_high_len   <= '0;
         r_match_cnt  <= '0;
         r_meas_ratio <= '0;
         r_meas_high  <= '0;
         r_meas_valid <= 1'b0;
         r_locked     <= 1'b0;
         r_err        <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_high_len   <= w_high_nxt;
         r_match_cnt  <= w_match_nxt;
         r_meas_ratio <= w_meas_ratio_nxt;
         r_meas_high  <= w_meas_high_nxt;
         r_meas_valid <= w_valid_nxt;
         r_locked     <= w_locked_nxt;
         r_err        <= w_err_nxt;
         r_timeout    <= w_timeout_nxt;
      end
   end

   assign o_meas_ratio = r_meas_ratio;
   assign o_meas_high  = r_meas_high;
   assign o_meas_valid = r_meas_valid;
   assign o_locked     = r_locked;
   assign o_err        = r_err;
   assign o_timeout    = r_timeout;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Scoreboard bench for clock_ratio_monitor: each driven period pushes its expected measurement,
// the negedge monitor pops and compares on every o_meas_valid.
module tb_clock_ratio_monitor;
   localparam int RW = 8;
   localparam int LK = 4;
   localparam int EW = 2 * RW + 2;
   localparam int MAXV = (1 << RW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          div;
   logic [RW-1:0] exp_ratio;
   logic [RW-1:0] o_meas_ratio;
   logic [RW-1:0] o_meas_high;
   logic          o_meas_valid;
   logic          o_locked;
   logic          o_err;
   logic          o_timeout;
   logic [1:0]    o_dbg_state;

   clock_ratio_monitor #(.RATIO_WD(RW), .LOCK_CNT(LK)) dut (
      .i_ref_clk    (clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_div_clk    (div),
      .i_exp_ratio  (exp_ratio),
      .o_meas_ratio (o_meas_ratio),
      .o_meas_high  (o_meas_high),
      .o_meas_valid (o_meas_valid),
      .o_locked     (o_locked),
      .o_err        (o_err),
      .o_timeout    (o_timeout),
      .o_dbg_state  (o_dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;
   logic [EW-1:0] exp_q[$];
   int   m_match = 0;
   int   to_cnt = 0;
   int   to_cyc = 0;
   int   last_valid_cyc = 0;
   int   n_valid = 0;
   logic to_locked = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // reference model: expected {err, locked, high, ratio} for a (h, l) period
   task automatic push_exp(input int h, input int l);
      int p;
      logic [RW-1:0] r;
      logic e;
      logic lk;
      p = h + l;
      r = (p > MAXV) ? RW'(MAXV) : RW'(p);
      if (p <= MAXV && RW'(p) == exp_ratio) begin
         if (m_match < LK) m_match++;
         e = 1'b0;
      end else begin
         m_match = 0;
         e = 1'b1;
      end
      lk = (m_match == LK);
      exp_q.push_back({e, lk, RW'(h), r});
   endtask

   // drivers
   task automatic drive_period(input int h, input int l, input bit chk);
      if (chk) push_exp(h, l);
      div = 1'b1;
      repeat (h) @(negedge clk);
      div = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic start(input int ratio);
      exp_ratio = RW'(ratio);
      en = 1'b1;
      m_match = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic close_and_idle();
      div = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check("q_drain", exp_q.size(), 0);
      en = 1'b0;
      @(negedge clk);
      div = 1'b0;
      repeat (3) @(negedge clk);
      m_match = 0;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (o_meas_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) check("unexp_valid", o_meas_valid, 1'b0);
            else check("meas", {o_err, o_locked, o_meas_high, o_meas_ratio}, exp_q.pop_front());
         end else begin
            check("err_no_valid", o_err, o_meas_valid);
         end
         if (o_timeout) begin
            to_cnt++;
            to_cyc = cyc;
            to_locked = o_locked;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int to_base;
      int v_base;
      rst = 1'b1;
      en = 1'b0;
      div = 1'b0;
      exp_ratio = '0;
      repeat (3) @(negedge clk);
      check("rst_outs", {o_meas_ratio, o_meas_high, o_meas_valid, o_locked, o_err, o_timeout}, 0);
      check("rst_state", o_dbg_state, 0);
      rst = 1'b0;
      @(negedge clk);

      // even ratio
      start(8);
      repeat (6) drive_period(4, 4, 1);
      close_and_idle();

      // odd ratio
      start(5);
      repeat (5) drive_period(2, 3, 1);
      close_and_idle();

      // mismatch while locked, then relock
      start(6);
      repeat (5) drive_period(3, 3, 1);
      drive_period(3, 4, 1);
      repeat (4) drive_period(3, 3, 1);
      close_and_idle();

      // stuck clock
      start(4);
      repeat (5) drive_period(2, 2, 1);
      to_base = to_cnt;
      div = 1'b1;
      repeat (280) @(negedge clk);
      check("to_count", to_cnt - to_base, 1);
      check("to_delay", to_cyc - last_valid_cyc, 254);
      check("to_unlock", to_locked, 1'b0);
      check("to_state", o_dbg_state, 1);
      div = 1'b0;
      m_match = 0;
      repeat (3) @(negedge clk);
      repeat (5) drive_period(2, 2, 1);
      close_and_idle();

      // period overflow saturates and mismatches
      start(200);
      drive_period(150, 150, 1);
      drive_period(100, 100, 1);
      close_and_idle();

      // bypass ratio: no activity at all
      to_base = to_cnt;
      v_base = n_valid;
      start(1);
      repeat (4) drive_period(3, 3, 0);
      div = 1'b1;
      repeat (300) @(negedge clk);
      check("byp_valid", n_valid - v_base, 0);
      check("byp_timeout", to_cnt - to_base, 0);
      check("byp_state", o_dbg_state, 0);
      div = 1'b0;
      en = 1'b0;
      @(negedge clk);

      // disable mid-period
      start(8);
      repeat (2) drive_period(4, 4, 1);
      div = 1'b1;
      repeat (5) @(negedge clk);
      check("dis_q", exp_q.size(), 0);
      en = 1'b0;
      @(negedge clk);
      check("dis_state", o_dbg_state, 0);
      check("dis_hold", {o_meas_high, o_meas_ratio}, {8'd4, 8'd8});
      check("dis_lock", o_locked, 1'b0);
      div = 1'b0;
      repeat (3) @(negedge clk);
      m_match = 0;

      // async reset in MEAS_LOW
      start(5);
      repeat (2) drive_period(2, 3, 1);
      div = 1'b1;
      repeat (2) @(negedge clk);
      div = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_state", o_dbg_state, 3);
      check("pre_rst_q", exp_q.size(), 0);
      rst = 1'b1;
      #1;
      check("mid_rst_outs", {o_meas_ratio, o_meas_high, o_meas_valid, o_locked, o_err, o_timeout}, 0);
      check("mid_rst_state", o_dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;
      m_match = 0;
      v_base = n_valid;
      repeat (3) @(negedge clk);
      drive_period(2, 3, 1);
      check("rst_no_early_valid", n_valid - v_base, 0);
      drive_period(2, 3, 1);
      close_and_idle();

      check("q_final", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/clock_ratio_monitor.md
# clock_ratio_monitor

Measures the period and high-phase length of a divided clock, in cycles of the reference clock that produced it, and checks the result against the expected division ratio. It sits beside the clock divider on the reference clock domain. It reports per-period measurements, a lock indication after repeated matches, mismatch errors and a stuck-clock timeout for the system controller and the bring-up registers.

## Interface
- RATIO_WD, 8, width of ratio, measurement and phase counters
- LOCK_CNT, 4, consecutive matching periods required to assert lock (1..15)

- i_ref_clk  in  1  reference clock; sole clock
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  1  monitor enable
- i_div_clk  in  1  divided clock under test, sampled as data
- i_exp_ratio  in  RATIO_WD  expected division ratio
- o_meas_ratio  out  RATIO_WD  last measured period, in i_ref_clk cycles
- o_meas_high  out  RATIO_WD  last measured high-phase length
- o_meas_valid  out  1  one-cycle pulse when o_meas_ratio/o_meas_high update
- o_locked  out  1  LOCK_CNT consecutive periods equal to i_exp_ratio
- o_err  out  1  one-cycle pulse on a measured period != i_exp_ratio
- o_timeout  out  1  one-cycle pulse when no edge is seen for 2^RATIO_WD-1 cycles

## Operation
- Sample path: i_div_clk → s (see Configuration); s_d = s delayed one cycle; rise = s & ~s_d; fall = ~s & s_d.
- Active = i_en && (i_exp_ratio >= 2). Ratios 0/1 mean divider bypass, so the monitor stays in IDLE and raises no timeout.
- FSM states:
  - IDLE: counters cleared, o_locked=0. Go to WAIT_RISE when Active.
  - WAIT_RISE: discards the partial first period. On rise: cnt←1, go to MEAS_HIGH.
  - MEAS_HIGH: cnt increments each cycle. On fall: high_len←cnt, cnt←1, go to MEAS_LOW.
  - MEAS_LOW: cnt increments each cycle. On rise: period = high_len + cnt, computed RATIO_WD+1 wide. Load o_meas_ratio and o_meas_high, pulse o_meas_valid, cnt←1, go to MEAS_HIGH.
- Any state other than IDLE returns to IDLE on the cycle after Active drops. Lock and match count clear. o_meas_* hold their last values.
- Period overflow: if period > 2^RATIO_WD-1, o_meas_ratio saturates to all-ones and the period is treated as a mismatch.
- Timeout: cnt counts in WAIT_RISE, MEAS_HIGH and MEAS_LOW, and saturates at all-ones. Reaching all-ones pulses o_timeout, clears lock and match count, sets cnt←0 and goes to WAIT_RISE.
- Lock: on each o_meas_valid the measured period is compared to i_exp_ratio.
  - Match: match_cnt increments, saturating at LOCK_CNT. o_locked=1 when match_cnt==LOCK_CNT.
  - Mismatch: o_err pulses, match_cnt←0, o_locked←0.
- A change of i_exp_ratio while Active takes effect at the next comparison. No restart.
- Expected divider shape for ratio N: high=N>>1, low=N-(N>>1).

## Timing
- Reset: all outputs 0, FSM IDLE, cnt/high_len/match_cnt 0, sampler flops 0.
- Sample latency L: 2 cycles with sync, 1 without, from the i_ref_clk edge where i_div_clk is first sampled at the new level to s.
- rise/fall are combinational from s and s_d. The FSM acts on them in the same cycle.
- o_meas_valid, o_meas_*, o_err and o_locked are registered and change one cycle after the rise that closes a period. o_err and o_meas_valid are coincident.
- o_locked asserts in the same cycle as the LOCK_CNT-th matching o_meas_valid.
- Simultaneous timeout and edge: the edge wins. The phase closes normally.
- Reset mid-period discards the partial measurement. No o_meas_valid is produced.

## Configuration
- CLK_MON_SYNC_EN defined: s is produced by a 2-flop synchronizer (L=2). Use for an i_div_clk that is asynchronous or glitch-prone.
- CLK_MON_SYNC_EN undefined: s is a single register (L=1). Valid only when i_div_clk is generated from i_ref_clk flops.
- Measurements are identical in both builds. Only latency differs.

## Test plan
- Even ratio: i_exp_ratio=8, i_div_clk 4 high/4 low → o_meas_ratio=8 and o_meas_high=4 every 8 cycles. o_locked=1 on the 4th valid. No o_err.
- Odd ratio: i_exp_ratio=5, 2 high/3 low → o_meas_ratio=5, o_meas_high=2. Lock after 4 periods.
- Mismatch while locked: locked at ratio 6, then inject one 7-cycle period → o_err pulse and o_locked=0 with that o_meas_valid. Relock after 4 further 6-cycle periods.
- Stuck clock: locked at ratio 4, hold i_div_clk=1 → o_timeout pulses 255 cycles after the last counted edge and o_locked=0. Resume toggling → relock.
- Bypass/disable: i_exp_ratio=1 with toggling input → no valid, err or timeout. i_en=0 mid-period → IDLE next cycle, o_meas_* hold.
- Async reset asserted mid-MEAS_LOW → all outputs 0 immediately. After release, the first period is discarded and the first o_meas_valid follows the second rise.
